prio_rotate_resolver: RTL
=========================

# prio_rotate_resolver

Parametrised interrupt priority resolver with rotating priority and in-service tracking for the PIC datapath. Takes the pending request vector, applies the mask, ranks requests against a registered lowest-priority pointer, and raises a registered interrupt request with the winning channel id. Holds the in-service register (ISR) and executes EOI, rotate and set-priority commands. The pointer and the ISR are registered state, so rotation persists across interrupts.

## Interface
- `N`, default 8: channel count, ≥2.
- `W`, default `$clog2(N)`: channel id width.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_i` in N: pending requests (IRR), level-sensitive.
- `mask_i` in N: 1 = channel masked.
- `ack_i` in 1: one-cycle acknowledge of the current `int_id_o`.
- `auto_eoi_i` in 1: auto-EOI mode select (see Configuration).
- `cmd_valid_i` in 1: command strobe, one cycle.
- `cmd_i` in 3: command code.
- `cmd_level_i` in W: level operand for specific commands.
- `int_o` out 1: interrupt request to the CPU, registered.
- `int_id_o` out W: winning channel, registered; valid while `int_o`=1.
- `isr_o` out N: in-service register.
- `ptr_o` out W: current lowest-priority channel.

## Operation
- Priority order: channel (ptr+1) mod N is highest, descending through wrap-around to ptr, which is lowest. The rank of channel c is (c − ptr − 1) mod N, computed at width W+1 and wrapped modulo N (N need not be a power of 2).
- Candidate: highest-ranked bit of `req_i & ~mask_i`.
- Highest ISR level: highest-ranked set bit of the ISR.
- `int_o` next = 1 iff a candidate exists and it outranks the highest ISR level, or the ISR is empty.
- `int_id_o` next = candidate id. It holds its previous value when there is no candidate.
- `ack_i` with `int_o`=1 sets `ISR[int_id_o]`. `ack_i` with `int_o`=0 is ignored.
- Commands, applied when `cmd_valid_i`=1:
  - 001: non-specific EOI; clear the highest ISR level.
  - 011: specific EOI; clear `ISR[cmd_level_i]`.
  - 101: rotate on non-specific EOI; clear the highest ISR level and set ptr to that level.
  - 111: rotate on specific EOI; clear `ISR[cmd_level_i]` and set ptr = `cmd_level_i`.
  - 110: set priority; ptr = `cmd_level_i`.
  - 100 / 000: set / clear the rotate_auto flag.
  - 010: no-op.
- Non-specific EOI with an empty ISR: no ISR change and no rotation.
- `cmd_level_i` ≥ N: the command is ignored entirely.
- `ack_i` and a command in the same cycle: the command is evaluated against the pre-ack ISR, then the ack set is applied. If both touch the same bit, the set wins.
- Reset values: ISR=0, ptr=N−1 (channel 0 highest), rotate_auto=0, `int_o`=0, `int_id_o`=0.

## Timing
- `int_o` / `int_id_o` are registered from the next-state ISR and ptr plus the current `req_i` and `mask_i`. Latency is 1 cycle from a request or mask change.
- On an ack edge the ISR bit sets and `int_o` re-evaluates on the same edge. For the same request held high, `int_o` is 0 in the following cycle.
- An EOI or rotation takes effect in ISR, ptr and `int_o` on the same edge. Any pending lower request appears on `int_o` the cycle after the command.
- Asserting `reset` mid-operation clears all state immediately, independent of `clk`.

## Configuration
- Macro `PRIO_AUTO_EOI_EN` defined:
  - An ack with `auto_eoi_i`=1 does not set the ISR bit.
  - If rotate_auto=1, that ack also sets ptr to the acknowledged id.
- Macro undefined:
  - `auto_eoi_i` is ignored and every ack sets the ISR.
  - The rotate_auto flag is still written by commands 100/000 but has no effect.

## Test plan
All scenarios use N=8.
- Reset, then `req_i`=0x30 and `mask_i`=0 → next cycle `int_o`=1, `int_id_o`=4. Ack → `isr_o`=0x10, `int_o`=0.
- ISR=0x10 with `req_i`=0x04 arriving → `int_o`=1, id 2 (nesting). With `req_i`=0x20 only → `int_o` stays 0.
- Set priority (110) with level 3, then `req_i`=0x05 → id 0 wins? No: ptr=3, so order is 4..7,0..3. `req_i`=0x05 → id 0; `req_i`=0x11 → id 4.
- ISR=0x48, command 101 → ISR=0x08 if level 6 outranks 3 under ptr=3. Otherwise ISR=0x40 and ptr=3. Check `ptr_o`.
- Ack and specific EOI of level 5 in the same cycle with id 5 → `isr_o[5]`=1.
- With `PRIO_AUTO_EOI_EN`, rotate_auto=1 and `auto_eoi_i`=1: ack id 2 → ISR unchanged and ptr=2. Assert `reset` mid-sequence → all outputs 0 and `ptr_o`=7.

Source files
------------

// File: rtl/prio_rotate_resolver.sv
// prio_rotate_resolver
// Interrupt priority resolver with a rotating lowest-priority pointer and an
// in-service register (ISR). Ranks masked requests against the registered
// pointer, raises a registered interrupt with the winning channel id, and
// executes EOI / rotate / set-priority commands.
//
// Optional feature macro: PRIO_AUTO_EOI_EN
//   defined   : an ack with auto_eoi_i=1 leaves the ISR untouched and, when the
//               rotate_auto flag is set, moves the pointer to the acked id.
//   undefined : auto_eoi_i is ignored; every accepted ack sets its ISR bit.
//               The rotate_auto flag is still written but has no effect.
module prio_rotate_resolver #(
  parameter int N = 8,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] mask_i,
  input  logic         ack_i,
  input  logic         auto_eoi_i,
  input  logic         cmd_valid_i,
  input  logic [2:0]   cmd_i,
  input  logic [W-1:0] cmd_level_i,
  output logic         int_o,
  output logic [W-1:0] int_id_o,
  output logic [N-1:0] isr_o,
  output logic [W-1:0] ptr_o
);

  localparam logic [W:0]   LP_N       = (W+1)'(N);
  localparam logic [W-1:0] LP_PTR_RST = (W)'(N - 1);

  localparam logic [2:0] CMD_ROT_CLR = 3'b000;
  localparam logic [2:0] CMD_NS_EOI  = 3'b001;
  localparam logic [2:0] CMD_NOP     = 3'b010;
  localparam logic [2:0] CMD_SP_EOI  = 3'b011;
  localparam logic [2:0] CMD_ROT_SET = 3'b100;
  localparam logic [2:0] CMD_ROT_NS  = 3'b101;
  localparam logic [2:0] CMD_SET_PRI = 3'b110;
  localparam logic [2:0] CMD_ROT_SP  = 3'b111;

  // Reduce a value in [0, 2N-1] into [0, N-1]; N need not be a power of two.
  function automatic logic [W-1:0] f_wrap(input logic [W:0] v);
    logic [W:0] t;
    t = (v >= LP_N) ? (v - LP_N) : v;
    return t[W-1:0];
  endfunction

  // Rank 0 is the highest priority, i.e. channel ptr+1.
  function automatic logic [W-1:0] f_rank(input logic [W-1:0] c, input logic [W-1:0] p);
    return f_wrap({1'b0, c} + LP_N - {1'b0, p} - (W+1)'(1));
  endfunction

  // Returns {found, id} of the highest-ranked set bit of v under pointer p.
  // Walks from lowest to highest priority so the last hit is the winner.
  function automatic logic [W:0] f_pick(input logic [N-1:0] v, input logic [W-1:0] p);
    logic         found;
    logic [W-1:0] id;
    logic [W-1:0] ch;
    found = 1'b0;
    id    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      ch = f_wrap({1'b0, p} + (W+1)'(1) + (W+1)'(k));
      if (v[ch]) begin
        found = 1'b1;
        id    = ch;
      end
    end
    return {found, id};
  endfunction

  logic [N-1:0] r_isr;
  logic [W-1:0] r_ptr;
  logic         r_rot_auto;
  logic         r_int;
  logic [W-1:0] r_int_id;

  logic [N-1:0] w_nx_isr;
  logic [W-1:0] w_nx_ptr;
  logic         w_nx_rot;
  logic         w_nx_int;
  logic [W-1:0] w_nx_id;

  logic [W:0]   w_isr_top_cur;
  logic [W:0]   w_isr_top_nx;
  logic [W:0]   w_cand;
  logic [N-1:0] w_req_eff;
  logic         w_lvl_ok;
  logic         w_cmd_ok;
  logic         w_ack_ok;
  logic [W-1:0] w_rank_cand;
  logic [W-1:0] w_rank_isr;

  assign w_lvl_ok      = ({1'b0, cmd_level_i} < LP_N);
  assign w_cmd_ok      = cmd_valid_i && w_lvl_ok;
  assign w_ack_ok      = ack_i && r_int;
  assign w_isr_top_cur = f_pick(r_isr, r_ptr);
  assign w_req_eff     = req_i & ~mask_i;

`ifndef PRIO_AUTO_EOI_EN
  logic w_unused_auto_eoi;
  assign w_unused_auto_eoi = auto_eoi_i;
`endif

  // Next ISR / pointer / rotate_auto: command against the pre-ack ISR first,
  // then the ack set, so a same-bit clear and set resolves to set.
  always_comb begin
    w_nx_isr = r_isr;
    w_nx_ptr = r_ptr;
    w_nx_rot = r_rot_auto;
    if (w_cmd_ok) begin
      case (cmd_i)
        CMD_NS_EOI: begin
          if (w_isr_top_cur[W]) w_nx_isr[w_isr_top_cur[W-1:0]] = 1'b0;
        end
        CMD_SP_EOI: begin
          w_nx_isr[cmd_level_i] = 1'b0;
        end
        CMD_ROT_NS: begin
          if (w_isr_top_cur[W]) begin
            w_nx_isr[w_isr_top_cur[W-1:0]] = 1'b0;
            w_nx_ptr                       = w_isr_top_cur[W-1:0];
          end
        end
        CMD_ROT_SP: begin
          w_nx_isr[cmd_level_i] = 1'b0;
          w_nx_ptr              = cmd_level_i;
        end
        CMD_SET_PRI: w_nx_ptr = cmd_level_i;
        CMD_ROT_SET: w_nx_rot = 1'b1;
        CMD_ROT_CLR: w_nx_rot = 1'b0;
        CMD_NOP:     w_nx_rot = r_rot_auto;
        default:     w_nx_rot = r_rot_auto;
      endcase
    end
`ifdef PRIO_AUTO_EOI_EN
    if (w_ack_ok) begin
      if (auto_eoi_i) begin
        if (r_rot_auto) w_nx_ptr = r_int_id;
      end else begin
        w_nx_isr[r_int_id] = 1'b1;
      end
    end
`else
    if (w_ack_ok) w_nx_isr[r_int_id] = 1'b1;
`endif
  end

  assign w_cand       = f_pick(w_req_eff, w_nx_ptr);
  assign w_isr_top_nx = f_pick(w_nx_isr, w_nx_ptr);
  assign w_rank_cand  = f_rank(w_cand[W-1:0], w_nx_ptr);
  assign w_rank_isr   = f_rank(w_isr_top_nx[W-1:0], w_nx_ptr);

  // Interrupt decision from next-state ISR/pointer and current requests;
  // a candidate must strictly outrank the highest in-service level.
  always_comb begin
    w_nx_int = w_cand[W] && (!w_isr_top_nx[W] || (w_rank_cand < w_rank_isr));
    w_nx_id  = w_cand[W] ? w_cand[W-1:0] : r_int_id;
  end

  // State and registered outputs, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_isr      <= '0;
      r_ptr      <= LP_PTR_RST;
      r_rot_auto <= 1'b0;
      r_int      <= 1'b0;
      r_int_id   <= '0;
    end else begin
      r_isr      <= w_nx_isr;
      r_ptr      <= w_nx_ptr;
      r_rot_auto <= w_nx_rot;
      r_int      <= w_nx_int;
      r_int_id   <= w_nx_id;
    end
  end

  assign int_o    = r_int;
  assign int_id_o = r_int_id;
  assign isr_o    = r_isr;
  assign ptr_o    = r_ptr;

endmodule
